seq_mag_comp: RTL and testbench
===============================

Name: seq_mag_comp

Overview:
Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and supports unsigned and two's-complement modes. It uses a start/busy/done handshake and exits early on the first differing digit. It replaces the fixed 4-bit combinational comparator wherever wide operands would make a single-cycle compare too slow.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT, minimum 2
DIGIT, 4, bits examined per clock; 1 <= DIGIT <= WIDTH
NCHUNK (localparam), WIDTH/DIGIT, number of digit slices per operand

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  compare in progress
done  output  1  single-cycle pulse; g/e/s are valid
g  output  1  A > B
e  output  1  A == B
s  output  1  A < B

Behaviour:
- States: IDLE, CMP, FIN. Reset (async, rst_n=0) forces IDLE. Reset values: busy=0, done=0, g=0, e=0, s=0, chunk counter=0, operand shift regs=0.
- IDLE / FIN with start=1, at edge T0:
  - Capture a and b into shift registers.
  - If signed_mode=1, invert bit WIDTH-1 of both captured operands (offset-binary). The rest of the compare is then unsigned.
  - Counter=0; go to CMP; busy=1 from T0.
- IDLE / FIN with start=0: FIN returns to IDLE after one cycle. IDLE holds.
- CMP, chunk i (counter=i), compares the top DIGIT bits of both shift registers:
  - Digits differ: at the next edge, register g/s from that digit (g=1 if A digit > B digit, else s=1), e=0, go to FIN.
  - Digits equal and i=NCHUNK-1: register e=1, g=0, s=0, go to FIN.
  - Digits equal and i<NCHUNK-1: shift both registers left by DIGIT, counter+1, stay in CMP.
- FIN: done=1, busy=0 for exactly that cycle.
- Latency: done is high in the cycle after edge T0+k, where k = number of chunks examined, 1 <= k <= NCHUNK. Best case 1 chunk, worst case NCHUNK.
- Output holding:
  - g/e/s change only at the deciding edge, and only one of them is 1 afterwards.
  - They hold until the next decision; a new start does not clear them early.
  - Before the first completion after reset, all three are 0.
- start while busy=1 (CMP) is ignored; a/b/signed_mode changes during CMP have no effect.
- start during the FIN cycle is accepted (back-to-back): the next compare begins; done still pulses only one cycle.
- rst_n asserted mid-compare: immediate return to IDLE, all outputs 0, no done pulse; operation abandoned.
- DIGIT=WIDTH degenerates to a single-chunk compare: k=1 always.

Test Plan:
- WIDTH=16, DIGIT=4, unsigned, a=16'hA5A5, b=16'hA5A5, start at T0 -> busy for 4 cycles, done in cycle after T0+4, e=1 g=0 s=0.
- Unsigned a=16'h8000, b=16'h7FFF -> early exit after chunk 0, done in cycle after T0+1, g=1. Repeat with signed_mode=1 -> s=1, same latency.
- Unsigned a=16'h1234, b=16'h1235 -> differ in last chunk, done after T0+4, s=1. Signed a=16'hFFFF (-1), b=16'hFFFE (-2) -> g=1, done after T0+4.
- start pulsed again during CMP with different operands -> ignored, result matches first operands. Then start in the FIN cycle with a=0, b=1 -> second compare runs, s=1 after its done.
- rst_n low at T0+2 of a 4-chunk compare -> busy, done, g, e, s all 0 immediately; no done pulse after release; next start behaves normally.
- WIDTH=8, DIGIT=1: random 500-pair sweep in both modes -> g/e/s match a reference compare; done latency equals 1 + index of first differing bit from MSB, or 8 if equal.

Source files
------------

// File: rtl/seq_mag_comp.sv
// seq_mag_comp: multi-cycle magnitude comparator for wide operands.
// The operands are compared MSB-first, DIGIT bits per clock. The compare
// stops at the first digit that differs. Signed mode flips the sign bit of
// both operands when they are captured (offset binary), so the digit
// compare itself is always unsigned.
//
// Handshake: start is sampled only while busy=0 (IDLE or FIN). An accepted
// start raises busy at that edge. When a result is decided, done pulses
// high for exactly one cycle and g/e/s are valid from that cycle. g/e/s
// hold until the next decision. start during CMP is ignored. start during
// the FIN cycle begins the next compare back-to-back.
module seq_mag_comp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             s,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, g_q, e_q, s_q;

  logic [WIDTH-1:0] a_d, b_d;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             last_chunk;

  // Operand load values: in signed mode the sign bit is flipped so that an unsigned compare orders them correctly
  always_comb begin
    a_d = a;
    b_d = b;
    if (signed_mode) begin
      a_d[WIDTH-1] = ~a[WIDTH-1];
      b_d[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  assign a_dig      = a_q[WIDTH-1 -: DIGIT];
  assign b_dig      = b_q[WIDTH-1 -: DIGIT];
  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CMP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CMP: begin
          if (a_dig != b_dig) begin
            g_q     <= (a_dig > b_dig);
            s_q     <= (a_dig < b_dig);
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (last_chunk) begin
            g_q     <= 1'b0;
            s_q     <= 1'b0;
            e_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            a_q   <= a_q << DIGIT;
            b_q   <= b_q << DIGIT;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign g         = g_q;
  assign e         = e_q;
  assign s         = s_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: one 16/4 instance for the directed cases and one
// 8/1 instance for a randomised sweep. Expected {latency, g, e, s} entries
// are queued when a start is driven. A monitor per instance pops an entry
// on each done pulse and compares the entry against the DUT outputs.
`timescale 1ns/1ps
module tb_seq_mag_comp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- DUT 16/4 ----------------
  logic        st16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, g16, e16, s16;
  logic [1:0]  dbg16;

  seq_mag_comp #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16),
    .g(g16), .e(e16), .s(s16), .dbg_state(dbg16)
  );

  // ---------------- DUT 8/1 ----------------
  logic        st8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, g8, e8, s8;
  logic [1:0]  dbg8;

  seq_mag_comp #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .g(g8), .e(e8), .s(s8), .dbg_state(dbg8)
  );

  // Expected entry: {latency[7:0], g, e, s}
  logic [10:0] exp16_q[$];
  logic [10:0] exp8_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer compare plus index of first differing digit
  function automatic logic [10:0] model(input int w, input int d,
                                        input logic [15:0] av, input logic [15:0] bv,
                                        input logic sm);
    int sa, sb, n, lat, da, db, sh, mask;
    n = w / d;
    lat = n;
    mask = (1 << d) - 1;
    for (int i = 0; i < n; i++) begin
      sh = w - (i + 1) * d;
      da = (int'(av) >> sh) & mask;
      db = (int'(bv) >> sh) & mask;
      if (da != db) begin
        lat = i + 1;
        break;
      end
    end
    sa = int'(av);
    sb = int'(bv);
    if (sm && av[w-1]) sa = sa - (1 << w);
    if (sm && bv[w-1]) sb = sb - (1 << w);
    return {8'(lat), sa > sb, sa == sb, sa < sb};
  endfunction

  // ---------------- scoreboard monitors ----------------
  int t0_16 = 0;
  int t0_8  = 0;

  always @(negedge clk) begin
    logic [10:0] ev;
    if (rst_n) begin
      if (done16) begin
        check("d16_busy_at_done", busy16, 0);
        if (exp16_q.size() == 0) check("d16_spurious_done", 1, 0);
        else begin
          ev = exp16_q.pop_front();
          check("d16_g", g16, ev[2]);
          check("d16_e", e16, ev[1]);
          check("d16_s", s16, ev[0]);
          check("d16_latency", cyc - t0_16, 32'(ev[10:3]));
        end
      end
      if (st16 && !busy16) t0_16 = cyc + 1;
    end
  end

  always @(negedge clk) begin
    logic [10:0] ev;
    if (rst_n) begin
      if (done8) begin
        if (exp8_q.size() == 0) check("d8_spurious_done", 1, 0);
        else begin
          ev = exp8_q.pop_front();
          check("d8_ges", {g8, e8, s8}, ev[2:0]);
          check("d8_latency", cyc - t0_8, 32'(ev[10:3]));
        end
      end
      if (st8 && !busy8) t0_8 = cyc + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic sm);
    a16 = av; b16 = bv; sm16 = sm; st16 = 1'b1;
    exp16_q.push_back(model(16, 4, av, bv, sm));
    @(posedge clk); #1;
    st16 = 1'b0;
  endtask

  task automatic wait_done16();
    int n = 0;
    while (!done16 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done16) check("d16_timeout", 0, 1);
  endtask

  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    a8 = av; b8 = bv; sm8 = sm; st8 = 1'b1;
    exp8_q.push_back(model(8, 1, {8'h00, av}, {8'h00, bv}, sm));
    @(posedge clk); #1;
    st8 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done8) check("d8_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    check("rst_ges", {g16, e16, s16}, 3'b000);
    check("rst_state", dbg16, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ges", {g16, e16, s16}, 3'b000);

    // Equal operands: full 4 chunks
    start16(16'hA5A5, 16'hA5A5, 1'b0);
    check("busy_after_start", busy16, 1);
    wait_done16();
    // Back-to-back start in FIN; previous result must still be held
    start16(16'h8000, 16'h7FFF, 1'b0);
    check("hold_ges", {g16, e16, s16}, 3'b010);
    wait_done16();
    @(posedge clk); #1;
    start16(16'h8000, 16'h7FFF, 1'b1);
    wait_done16();
    @(posedge clk); #1;
    start16(16'h1234, 16'h1235, 1'b0);
    wait_done16();
    @(posedge clk); #1;
    start16(16'hFFFF, 16'hFFFE, 1'b1);
    wait_done16();
    @(posedge clk); #1;

    // start during CMP is ignored
    start16(16'h1234, 16'h1235, 1'b0);
    a16 = 16'hFFFF; b16 = 16'h0000; sm16 = 1'b1; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    wait_done16();
    start16(16'h0000, 16'h0001, 1'b0);
    wait_done16();
    @(posedge clk); #1;

    // Reset in the middle of a 4-chunk compare
    start16(16'h1234, 16'h1235, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy16, 0);
    check("abort_done", done16, 0);
    check("abort_ges", {g16, e16, s16}, 3'b000);
    check("abort_state", dbg16, 0);
    void'(exp16_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_abort_ges", {g16, e16, s16}, 3'b000);
    start16(16'h0005, 16'h0003, 1'b0);
    wait_done16();
    @(posedge clk); #1;

    // Random 16-bit compares in both modes
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom_range(0, 65535));
      y = ($urandom_range(0, 3) == 0) ? x ^ 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 65535));
      start16(x, y, 1'($urandom_range(0, 1)));
      wait_done16();
    end
    @(posedge clk); #1;

    // WIDTH=8 DIGIT=1 sweep, back-to-back starts in the FIN cycle
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom_range(0, 255));
      endcase
      start8(ra, rb, 1'(i & 1));
      wait_done8();
    end

    repeat (4) @(posedge clk);
    #1;
    check("d16_queue_drained", exp16_q.size(), 0);
    check("d8_queue_drained", exp8_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
